// File: rtl/reg_decode_exe.sv
// -----------------------------------------------------------------------------
// reg_decode_exe
//
// Decode/Execute pipeline register for the filter processor. It captures the
// decoded operands and control from the decode stage and presents them to the
// execute stage and the forwarding unit. A load whose result is needed by the
// very next instruction cannot be forwarded in time. In that case the block
// stalls decode and inserts LOAD_STALL bubbles into execute.
//
// Parameters
//   DATA_W      operand / immediate width
//   LOAD_STALL  bubbles inserted per load-use hazard (1..7)
//
// Ports
//   clk, rst_n                      clock, asynchronous active-low reset
//   *_D                             decoded instruction fields from decode
//   valid_D                         decode slot holds a real instruction
//   flush                           branch taken: discard the decode slot
//   mem_busy                        memory stage not ready: freeze everything
//   *_Reg_Exe, *_Exe, valid_Exe     registered execute-stage copies
//   stall_D                         combinational: hold fetch/decode this cycle
// -----------------------------------------------------------------------------
module reg_decode_exe #(
    parameter int DATA_W     = 16,
    parameter int LOAD_STALL = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        Ra_D,
    input  logic [3:0]        Rb_D,
    input  logic [3:0]        Robj_D,
    input  logic              RE_A_D,
    input  logic              RE_B_D,
    input  logic              WE_D,
    input  logic              mem_WE_D,
    input  logic              mem_RE_D,
    input  logic [3:0]        alu_op_D,
    input  logic [DATA_W-1:0] dataA_D,
    input  logic [DATA_W-1:0] dataB_D,
    input  logic [DATA_W-1:0] imm_D,
    input  logic              valid_D,
    input  logic              flush,
    input  logic              mem_busy,
    output logic [3:0]        Ra_Reg_Exe,
    output logic [3:0]        Rb_Reg_Exe,
    output logic [3:0]        Robj_Reg_Exe,
    output logic              RE_A_Reg_Exe,
    output logic              RE_B_Reg_Exe,
    output logic              WE_Reg_Exe,
    output logic              mem_WE_Reg_Exe,
    output logic              mem_RE_Reg_Exe,
    output logic [3:0]        alu_op_Exe,
    output logic [DATA_W-1:0] dataA_Exe,
    output logic [DATA_W-1:0] dataB_Exe,
    output logic [DATA_W-1:0] imm_Exe,
    output logic              valid_Exe,
    output logic              stall_D
);

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } state_t;

    // One execute-stage slot; an all-zero slot is a bubble.
    typedef struct packed {
        logic [3:0]        ra;
        logic [3:0]        rb;
        logic [3:0]        robj;
        logic              re_a;
        logic              re_b;
        logic              we;
        logic              mem_we;
        logic              mem_re;
        logic [3:0]        alu_op;
        logic [DATA_W-1:0] data_a;
        logic [DATA_W-1:0] data_b;
        logic [DATA_W-1:0] imm;
        logic              valid;
    } exe_t;

    // The hazard cycle itself emits the first bubble, so the STALL state only
    // has to cover the remaining LOAD_STALL-1 of them.
    localparam logic [2:0] STALL_RELOAD = 3'(LOAD_STALL - 1);
    localparam bit         MULTI_BUBBLE = (LOAD_STALL > 1);

    state_t     state_q;
    state_t     state_d;
    logic [2:0] cnt_q;
    logic [2:0] cnt_d;
    exe_t       exe_q;
    exe_t       exe_d;
    exe_t       dec_s;
    logic       hazard_s;

    assign dec_s = {Ra_D, Rb_D, Robj_D, RE_A_D, RE_B_D, WE_D, mem_WE_D, mem_RE_D,
                    alu_op_D, dataA_D, dataB_D, imm_D, valid_D};

    // Load-use detection: a valid load in execute writing a register that the
    // valid decode instruction actually reads. R0 is an ordinary register here.
    always_comb begin
        hazard_s = exe_q.valid & exe_q.mem_re & exe_q.we & valid_D &
                   ((RE_A_D & (Ra_D == exe_q.robj)) |
                    (RE_B_D & (Rb_D == exe_q.robj)));
    end

    // Decode hold request; a flush in RUN cancels the hazard stall because the
    // dependent instruction is being discarded anyway.
    always_comb begin
        stall_D = mem_busy | (state_q == STALL) |
                  ((state_q == RUN) & hazard_s & ~flush);
    end

    // Next-state / next-slot selection: freeze, flush, hazard, stall, capture.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        exe_d   = exe_q;
        if (mem_busy) begin
            state_d = state_q;
            cnt_d   = cnt_q;
            exe_d   = exe_q;
        end else if (flush) begin
            state_d = RUN;
            cnt_d   = 3'd0;
            exe_d   = '0;
        end else begin
            case (state_q)
                RUN: begin
                    if (hazard_s) begin
                        exe_d = '0;
                        if (MULTI_BUBBLE) begin
                            state_d = STALL;
                            cnt_d   = STALL_RELOAD;
                        end else begin
                            state_d = RUN;
                            cnt_d   = cnt_q;
                        end
                    end else begin
                        exe_d   = dec_s;
                        state_d = RUN;
                        cnt_d   = cnt_q;
                    end
                end
                STALL: begin
                    exe_d = '0;
                    cnt_d = cnt_q - 3'd1;
                    if (cnt_q == 3'd1) begin
                        state_d = RUN;
                    end else begin
                        state_d = STALL;
                    end
                end
                default: begin
                    exe_d   = '0;
                    state_d = RUN;
                    cnt_d   = 3'd0;
                end
            endcase
        end
    end

    // State, bubble counter and execute-slot registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            cnt_q   <= 3'd0;
            exe_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            exe_q   <= exe_d;
        end
    end

    assign Ra_Reg_Exe     = exe_q.ra;
    assign Rb_Reg_Exe     = exe_q.rb;
    assign Robj_Reg_Exe   = exe_q.robj;
    assign RE_A_Reg_Exe   = exe_q.re_a;
    assign RE_B_Reg_Exe   = exe_q.re_b;
    assign WE_Reg_Exe     = exe_q.we;
    assign mem_WE_Reg_Exe = exe_q.mem_we;
    assign mem_RE_Reg_Exe = exe_q.mem_re;
    assign alu_op_Exe     = exe_q.alu_op;
    assign dataA_Exe      = exe_q.data_a;
    assign dataB_Exe      = exe_q.data_b;
    assign imm_Exe        = exe_q.imm;
    assign valid_Exe      = exe_q.valid;

endmodule

// File: tb/tb_reg_decode_exe.sv
// -----------------------------------------------------------------------------
// tb_reg_decode_exe
//
// Two instances (LOAD_STALL = 1 and 3) share one decode stimulus. A reference
// model tracks, per instance, the execute slot and the number of bubbles
// still owed; every cycle stall_D and all execute outputs are compared.
// A table of directed vectors covers the load-use corner cases, followed by
// hand-written reset sequences and a randomized run.
// -----------------------------------------------------------------------------
module tb_reg_decode_exe;

    typedef struct packed {
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic [3:0]  robj;
        logic        re_a;
        logic        re_b;
        logic        we;
        logic        mem_we;
        logic        mem_re;
        logic [3:0]  alu_op;
        logic [15:0] data_a;
        logic [15:0] data_b;
        logic [15:0] imm;
        logic        valid;
    } stage_t;

    typedef struct {
        logic [3:0] ra, rb, robj;
        logic       re_a, re_b, we, mem_we, mem_re, valid, flush, busy;
        logic       s1, s3, v1, v3;
    } vec_t;

    logic   clk;
    logic   rst_n;
    logic   flush;
    logic   busy;
    stage_t din;

    stage_t act_exe   [2];
    logic   act_stall [2];

    logic [3:0]  ra_o   [2], rb_o [2], robj_o [2], alu_o [2];
    logic        rea_o  [2], reb_o [2], we_o [2], mwe_o [2], mre_o [2], val_o [2];
    logic [15:0] da_o   [2], db_o [2], imm_o [2];

    int     n_chk;
    int     n_pass;
    stage_t mdl_exe  [2];
    int     mdl_pend [2];
    int     nst      [2];
    vec_t   tbl      [28];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    reg_decode_exe #(.DATA_W(16), .LOAD_STALL(1)) u_ls1 (
        .clk(clk), .rst_n(rst_n),
        .Ra_D(din.ra), .Rb_D(din.rb), .Robj_D(din.robj),
        .RE_A_D(din.re_a), .RE_B_D(din.re_b), .WE_D(din.we),
        .mem_WE_D(din.mem_we), .mem_RE_D(din.mem_re), .alu_op_D(din.alu_op),
        .dataA_D(din.data_a), .dataB_D(din.data_b), .imm_D(din.imm),
        .valid_D(din.valid), .flush(flush), .mem_busy(busy),
        .Ra_Reg_Exe(ra_o[0]), .Rb_Reg_Exe(rb_o[0]), .Robj_Reg_Exe(robj_o[0]),
        .RE_A_Reg_Exe(rea_o[0]), .RE_B_Reg_Exe(reb_o[0]), .WE_Reg_Exe(we_o[0]),
        .mem_WE_Reg_Exe(mwe_o[0]), .mem_RE_Reg_Exe(mre_o[0]), .alu_op_Exe(alu_o[0]),
        .dataA_Exe(da_o[0]), .dataB_Exe(db_o[0]), .imm_Exe(imm_o[0]),
        .valid_Exe(val_o[0]), .stall_D(act_stall[0])
    );

    reg_decode_exe #(.DATA_W(16), .LOAD_STALL(3)) u_ls3 (
        .clk(clk), .rst_n(rst_n),
        .Ra_D(din.ra), .Rb_D(din.rb), .Robj_D(din.robj),
        .RE_A_D(din.re_a), .RE_B_D(din.re_b), .WE_D(din.we),
        .mem_WE_D(din.mem_we), .mem_RE_D(din.mem_re), .alu_op_D(din.alu_op),
        .dataA_D(din.data_a), .dataB_D(din.data_b), .imm_D(din.imm),
        .valid_D(din.valid), .flush(flush), .mem_busy(busy),
        .Ra_Reg_Exe(ra_o[1]), .Rb_Reg_Exe(rb_o[1]), .Robj_Reg_Exe(robj_o[1]),
        .RE_A_Reg_Exe(rea_o[1]), .RE_B_Reg_Exe(reb_o[1]), .WE_Reg_Exe(we_o[1]),
        .mem_WE_Reg_Exe(mwe_o[1]), .mem_RE_Reg_Exe(mre_o[1]), .alu_op_Exe(alu_o[1]),
        .dataA_Exe(da_o[1]), .dataB_Exe(db_o[1]), .imm_Exe(imm_o[1]),
        .valid_Exe(val_o[1]), .stall_D(act_stall[1])
    );

    assign act_exe[0] = {ra_o[0], rb_o[0], robj_o[0], rea_o[0], reb_o[0], we_o[0],
                         mwe_o[0], mre_o[0], alu_o[0], da_o[0], db_o[0], imm_o[0], val_o[0]};
    assign act_exe[1] = {ra_o[1], rb_o[1], robj_o[1], rea_o[1], reb_o[1], we_o[1],
                         mwe_o[1], mre_o[1], alu_o[1], da_o[1], db_o[1], imm_o[1], val_o[1]};

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit mdl_hazard(input stage_t e, input stage_t d);
        return e.valid && e.mem_re && e.we && d.valid &&
               ((d.re_a && (d.ra == e.robj)) || (d.re_b && (d.rb == e.robj)));
    endfunction

    task automatic mdl_reset();
        for (int k = 0; k < 2; k++) begin
            mdl_exe[k]  = '0;
            mdl_pend[k] = 0;
        end
    endtask

    // Compare current outputs, then advance the model across the coming edge.
    task automatic model_check_and_step();
        for (int k = 0; k < 2; k++) begin
            bit hz;
            bit exp_st;
            hz     = mdl_hazard(mdl_exe[k], din);
            exp_st = busy || (mdl_pend[k] > 0) || (hz && !flush);
            chk($sformatf("stall_D[ls%0d]", nst[k]), {127'd0, act_stall[k]}, {127'd0, exp_st});
            chk($sformatf("exe[ls%0d]", nst[k]), {58'd0, act_exe[k]}, {58'd0, mdl_exe[k]});
            if (busy) begin
                mdl_pend[k] = mdl_pend[k];
            end else if (flush) begin
                mdl_exe[k]  = '0;
                mdl_pend[k] = 0;
            end else if (mdl_pend[k] > 0) begin
                mdl_exe[k]  = '0;
                mdl_pend[k] = mdl_pend[k] - 1;
            end else if (hz) begin
                mdl_exe[k]  = '0;
                mdl_pend[k] = nst[k] - 1;
            end else begin
                mdl_exe[k] = din;
            end
        end
    endtask

    task automatic run_cycle();
        #1;
        model_check_and_step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_vec(input vec_t v, input int i);
        din        = '0;
        din.ra     = v.ra;
        din.rb     = v.rb;
        din.robj   = v.robj;
        din.re_a   = v.re_a;
        din.re_b   = v.re_b;
        din.we     = v.we;
        din.mem_we = v.mem_we;
        din.mem_re = v.mem_re;
        din.valid  = v.valid;
        din.alu_op = 4'(i);
        din.data_a = 16'(i * 3 + 1);
        din.data_b = 16'(i * 7 + 2);
        din.imm    = 16'(i + 100);
        flush      = v.flush;
        busy       = v.busy;
    endtask

    initial begin
        n_chk  = 0;
        n_pass = 0;
        nst[0] = 1;
        nst[1] = 3;
        mdl_reset();

        // cols: ra rb robj re_a re_b we mem_we mem_re valid flush busy | s1 s3 v1 v3
        tbl[0]  = '{4'd0,4'd0,4'd5,1'b0,1'b0,1'b1,1'b0,1'b1,1'b1,1'b0,1'b0, 1'b0,1'b0,1'b1,1'b1};
        tbl[1]  = '{4'd0,4'd5,4'd0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0, 1'b1,1'b1,1'b0,1'b0};
        tbl[2]  = '{4'd0,4'd5,4'd0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0, 1'b0,1'b1,1'b1,1'b0};
        tbl[3]  = '{4'd0,4'd5,4'd0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0, 1'b0,1'b1,1'b1,1'b0};
        tbl[4]  = '{4'd0,4'd5,4'd0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0, 1'b0,1'b0,1'b1,1'b1};
        tbl[5]  = '{4'd0,4'd0,4'd5,1'b0,1'b0,1'b1,1'b0,1'b1,1'b1,1'b0,1'b0, 1'b0,1'b0,1'b1,1'b1};
        tbl[6]  = '{4'd0,4'd5,4'd0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0, 1'b0,1'b0,1'b1,1'b1};
        tbl[7]  = '{4'd0,4'd0,4'd5,1'b0,1'b0,1'b1,1'b0,1'b1,1'b1,1'b0,1'b0, 1'b0,1'b0,1'b1,1'b1};
        tbl[8]  = '{4'd0,4'd5,4'd0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0, 1'b0,1'b0,1'b0,1'b0};
        tbl[9]  = '{4'd0,4'd0,4'd5,1'b0,1'b0,1'b1,1'b0,1'b1,1'b1,1'b0,1'b0, 1'b0,1'b0,1'b1,1'b1};
        tbl[10] = '{4'd0,4'd5,4'd0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0, 1'b1,1'b1,1'b0,1'b0};
        tbl[11] = '{4'd0,4'd5,4'd0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1, 1'b1,1'b1,1'b0,1'b0};
        tbl[12] = '{4'd0,4'd5,4'd0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1, 1'b1,1'b1,1'b0,1'b0};
        tbl[13] = '{4'd0,4'd5,4'd0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0, 1'b0,1'b1,1'b1,1'b0};
        tbl[14] = '{4'd0,4'd5,4'd0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0, 1'b0,1'b1,1'b1,1'b0};
        tbl[15] = '{4'd0,4'd5,4'd0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0, 1'b0,1'b0,1'b1,1'b1};
        tbl[16] = '{4'd0,4'd0,4'd5,1'b0,1'b0,1'b1,1'b0,1'b1,1'b1,1'b0,1'b0, 1'b0,1'b0,1'b1,1'b1};
        tbl[17] = '{4'd0,4'd5,4'd0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0, 1'b1,1'b1,1'b0,1'b0};
        tbl[18] = '{4'd0,4'd5,4'd0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0, 1'b0,1'b1,1'b0,1'b0};
        tbl[19] = '{4'd0,4'd5,4'd0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0, 1'b0,1'b0,1'b1,1'b1};
        tbl[20] = '{4'd0,4'd0,4'd7,1'b0,1'b0,1'b1,1'b0,1'b0,1'b1,1'b0,1'b0, 1'b0,1'b0,1'b1,1'b1};
        tbl[21] = '{4'd0,4'd7,4'd0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0, 1'b0,1'b0,1'b1,1'b1};
        tbl[22] = '{4'd0,4'd0,4'd0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b1,1'b0,1'b0, 1'b0,1'b0,1'b1,1'b1};
        tbl[23] = '{4'd0,4'd0,4'd0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0, 1'b1,1'b1,1'b0,1'b0};
        tbl[24] = '{4'd0,4'd0,4'd0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b1,1'b0,1'b0};
        tbl[25] = '{4'd0,4'd0,4'd0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b1,1'b0,1'b0};
        tbl[26] = '{4'd0,4'd0,4'd5,1'b0,1'b0,1'b1,1'b0,1'b1,1'b1,1'b0,1'b0, 1'b0,1'b0,1'b1,1'b1};
        tbl[27] = '{4'd0,4'd5,4'd0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0};

        // Reset: outputs clear, stall_D follows mem_busy.
        rst_n = 1'b0;
        din   = '0;
        flush = 1'b0;
        busy  = 1'b1;
        #2;
        chk("rst_stall_busy_ls1", {127'd0, act_stall[0]}, {127'd0, 1'b1});
        chk("rst_stall_busy_ls3", {127'd0, act_stall[1]}, {127'd0, 1'b1});
        chk("rst_exe_ls1", {58'd0, act_exe[0]}, 128'd0);
        chk("rst_exe_ls3", {58'd0, act_exe[1]}, 128'd0);
        busy = 1'b0;
        #1;
        chk("rst_stall_idle_ls3", {127'd0, act_stall[1]}, 128'd0);
        #5;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Normal instruction passes through with one cycle of latency.
        din        = '0;
        din.ra     = 4'd2;
        din.re_a   = 1'b1;
        din.data_a = 16'h1234;
        din.valid  = 1'b1;
        run_cycle();
        chk("normal_ra", {124'd0, ra_o[1]}, {124'd0, 4'd2});
        chk("normal_dataA", {112'd0, da_o[1]}, {112'd0, 16'h1234});
        chk("normal_valid", {127'd0, val_o[0]}, {127'd0, 1'b1});

        // Directed table.
        for (int i = 0; i < 28; i++) begin
            set_vec(tbl[i], i);
            #1;
            chk($sformatf("tbl%0d_stall_ls1", i), {127'd0, act_stall[0]}, {127'd0, tbl[i].s1});
            chk($sformatf("tbl%0d_stall_ls3", i), {127'd0, act_stall[1]}, {127'd0, tbl[i].s3});
            model_check_and_step();
            @(posedge clk);
            #1;
            chk($sformatf("tbl%0d_valid_ls1", i), {127'd0, val_o[0]}, {127'd0, tbl[i].v1});
            chk($sformatf("tbl%0d_valid_ls3", i), {127'd0, val_o[1]}, {127'd0, tbl[i].v3});
        end

        // Reset asserted in the middle of a stall: immediate clear, back to RUN.
        set_vec(tbl[0], 40);
        run_cycle();
        set_vec(tbl[1], 41);
        run_cycle();
        chk("pre_rst_in_stall_ls3", {127'd0, act_stall[1]}, {127'd0, 1'b1});
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_exe_ls1", {58'd0, act_exe[0]}, 128'd0);
        chk("midrst_exe_ls3", {58'd0, act_exe[1]}, 128'd0);
        chk("midrst_stall_ls3", {127'd0, act_stall[1]}, 128'd0);
        mdl_reset();
        #2;
        rst_n = 1'b1;
        #1;
        model_check_and_step();
        @(posedge clk);
        #1;
        chk("postrst_capture_ls3", {127'd0, val_o[1]}, {127'd0, 1'b1});
        set_vec(tbl[24], 42);
        run_cycle();

        // Randomized traffic against the reference model.
        for (int n = 0; n < 600; n++) begin
            din.ra     = 4'($urandom_range(0, 3));
            din.rb     = 4'($urandom_range(0, 3));
            din.robj   = 4'($urandom_range(0, 3));
            din.re_a   = 1'($urandom_range(0, 1));
            din.re_b   = 1'($urandom_range(0, 1));
            din.we     = 1'($urandom_range(0, 3) != 0);
            din.mem_we = 1'($urandom_range(0, 1));
            din.mem_re = 1'($urandom_range(0, 1));
            din.alu_op = 4'($urandom);
            din.data_a = 16'($urandom);
            din.data_b = 16'($urandom);
            din.imm    = 16'($urandom);
            din.valid  = 1'($urandom_range(0, 7) != 0);
            flush      = 1'($urandom_range(0, 9) == 0);
            busy       = 1'($urandom_range(0, 5) == 0);
            run_cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
